// File: rtl/mem_arbiter_if.sv
// One requester port of the Simplez memory arbiter: request/handshake plus data.
// The requester drives through 'master'; the arbiter receives through 'slave'.
interface mem_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 12
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input  ack, rdata);
    modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port Simplez main memory (port 0 = CPU,
// port 1 = loader/monitor); IDLE -> ISSUE -> DONE sequencer, one access per 3 clocks.
module mem_arbiter #(
    parameter int AW         = 9,
    parameter int DW         = 12,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  p0,
    mem_arbiter_if.slave  p1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_n;
    logic          owner_q, owner_n;
    logic          last_q,  last_n;
    logic [1:0]    ack_q,   ack_n;
    logic [DW-1:0] rdata0_q, rdata0_n;
    logic [DW-1:0] rdata1_q, rdata1_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] wdata_n;
    logic          re_n, we_n;

    logic          grant1;
    logic          sel_we;

    // Port 1 wins when alone, or on a round-robin tie when port 0 went last.
    assign grant1 = p1.req & (~p0.req | ((FIXED_PRIO == 0) & ~last_q));
    assign sel_we = grant1 ? p1.we : p0.we;

    // NOTE: every *_n gets its hold value first, so no path through the case leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_n  = state_q;
        owner_n  = owner_q;
        last_n   = last_q;
        ack_n    = 2'b00;
        rdata0_n = rdata0_q;
        rdata1_n = rdata1_q;
        addr_n   = mem_addr;
        wdata_n  = mem_wdata;
        re_n     = mem_re;
        we_n     = mem_we;

        case (state_q)
            IDLE: begin
                if (p0.req | p1.req) begin
                    owner_n = grant1;
                    addr_n  = grant1 ? p1.addr  : p0.addr;
                    wdata_n = grant1 ? p1.wdata : p0.wdata;
                    re_n    = ~sel_we;
                    we_n    = sel_we;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                // The memory has driven mem_rdata at the mid-cycle negedge.
                if (mem_re) begin
                    if (owner_q) rdata1_n = mem_rdata;
                    else         rdata0_n = mem_rdata;
                end
                ack_n[owner_q] = 1'b1;
                last_n         = owner_q;
                re_n           = 1'b0;
                we_n           = 1'b0;
                state_n        = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            ack_q     <= 2'b00;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
        end else begin
            state_q   <= state_n;
            owner_q   <= owner_n;
            last_q    <= last_n;
            ack_q     <= ack_n;
            rdata0_q  <= rdata0_n;
            rdata1_q  <= rdata1_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            mem_re    <= re_n;
            mem_we    <= we_n;
        end
    end

    assign p0.ack   = ack_q[0];
    assign p1.ack   = ack_q[1];
    assign p0.rdata = rdata0_q;
    assign p1.rdata = rdata1_q;
    assign busy     = (state_q != IDLE);

endmodule
